// File: rtl/pp_sched_pkg.sv
// Shared types and helpers for the ping-pong bank scheduler.
// Holds the per-bank ownership states, the write-address bit reversal and the depth check.
package pp_sched_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    FILLING  = 2'd1,
    READY    = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Reverses the low 'width' bits of value; bits at and above 'width' read as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] rev;
    rev = '0;
    for (int i = 0; i < width; i++) begin
      rev[i] = value[width-1-i];
    end
    return rev;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/pp_bank_fsm.sv
// Ownership state machine for one RAM bank: FREE -> FILLING -> READY -> DRAINING -> FREE.
module pp_bank_fsm
  import pp_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_hit,
  input  logic       wr_term,
  input  logic       rd_hit,
  input  logic       rd_term,
  output logic [1:0] state
);

  bank_state_t state_reg;
  bank_state_t state_next;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FREE:     if (wr_hit) state_next = wr_term ? READY : FILLING;
      FILLING:  if (wr_hit && wr_term) state_next = READY;
      READY:    if (rd_hit) state_next = rd_term ? FREE : DRAINING;
      DRAINING: if (rd_hit && rd_term) state_next = FREE;
      default:  state_next = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FREE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/pp_bank_sched.sv
// Ping-pong bank scheduler: hands two RAM banks alternately to a streaming writer and a
// frame reader, with back-pressure, in-order frame delivery and overflow reporting.
module pp_bank_sched
  import pp_sched_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter bit BITREV     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  rd_req,
  output logic                  rd_en,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [3:0]            bank_state
);

  if (!depth_ok(DEPTH)) begin : g_depth_check
    $error("pp_bank_sched: DEPTH must be a power of two and at least 2");
  end

  logic [1:0]            bank_st [2];
  logic                  wr_sel_reg, wr_sel_next;
  logic                  rd_sel_reg, rd_sel_next;
  logic [ADDR_WIDTH-1:0] wr_cnt_reg, wr_cnt_next;
  logic [ADDR_WIDTH-1:0] rd_cnt_reg, rd_cnt_next;
  logic                  rd_valid_reg, rd_last_reg, frame_done_reg;
  logic [1:0]            wr_st, rd_st;
  logic                  wr_term, rd_term;

  assign wr_st   = bank_st[wr_sel_reg];
  assign rd_st   = bank_st[rd_sel_reg];
  assign wr_term = (wr_cnt_reg == ADDR_WIDTH'(DEPTH - 1));
  assign rd_term = (rd_cnt_reg == ADDR_WIDTH'(DEPTH - 1));

  // Readiness looks only at registered state, so a bank freed this cycle is writable next cycle.
  assign wr_ready = (wr_st == FREE) || (wr_st == FILLING);
  assign wr_en    = wr_valid & wr_ready;
  assign wr_bank  = wr_sel_reg;
  assign wr_addr  = BITREV ? ADDR_WIDTH'(bitrev(32'(wr_cnt_reg), ADDR_WIDTH)) : wr_cnt_reg;
  assign overflow = wr_valid & ~wr_ready;

  assign rd_en   = rd_req & ((rd_st == READY) || (rd_st == DRAINING));
  assign rd_bank = rd_sel_reg;
  assign rd_addr = rd_cnt_reg;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_bank
    pp_bank_fsm u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_hit  (wr_en && (int'(wr_sel_reg) == gi)),
      .wr_term (wr_term),
      .rd_hit  (rd_en && (int'(rd_sel_reg) == gi)),
      .rd_term (rd_term),
      .state   (bank_st[gi])
    );
  end

  always_comb begin
    wr_cnt_next = wr_cnt_reg;
    wr_sel_next = wr_sel_reg;
    rd_cnt_next = rd_cnt_reg;
    rd_sel_next = rd_sel_reg;
    if (wr_en) begin
      wr_cnt_next = wr_term ? '0 : wr_cnt_reg + ADDR_WIDTH'(1);
      if (wr_term) wr_sel_next = ~wr_sel_reg;
    end
    if (rd_en) begin
      rd_cnt_next = rd_term ? '0 : rd_cnt_reg + ADDR_WIDTH'(1);
      if (rd_term) rd_sel_next = ~rd_sel_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_reg     <= '0;
      wr_sel_reg     <= 1'b0;
      rd_cnt_reg     <= '0;
      rd_sel_reg     <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      wr_cnt_reg     <= wr_cnt_next;
      wr_sel_reg     <= wr_sel_next;
      rd_cnt_reg     <= rd_cnt_next;
      rd_sel_reg     <= rd_sel_next;
      rd_valid_reg   <= rd_en;
      rd_last_reg    <= rd_en & rd_term;
      frame_done_reg <= rd_en & rd_term;
    end
  end

  assign rd_valid   = rd_valid_reg;
  assign rd_last    = rd_last_reg;
  assign frame_done = frame_done_reg;
  assign bank_state = {bank_st[1], bank_st[0]};

endmodule
